// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding and LED defaults.
package led_pkg;

    localparam int unsigned LED_W_DEF = 18;
    localparam logic [LED_W_DEF-1:0] LED_OFF = '0;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_ACTIVE = 3'd1;
    localparam seq_state_t ST_GAP    = 3'd2;
    localparam seq_state_t ST_DONE   = 3'd3;
    localparam seq_state_t ST_ERROR  = 3'd4;

endpackage

// File: rtl/led_seq_watchdog.sv
// Per-state watchdog: counts enabled cycles and flags the cycle that reaches the limit.
module led_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_async_rs_n,
    input  logic i_clear,
    input  logic i_count,
    input  logic i_hold,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;
    logic          w_step;

    assign w_tc     = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_step   = i_count && !i_hold;
    // Expiry fires on the edge that would complete the last allowed cycle.
    assign o_expire = w_step && w_tc;

    always_ff @(posedge i_clk or negedge i_async_rs_n) begin
        if (!i_async_rs_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_step && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Initiator-side sequencer: walks pattern blocks with a begin/over handshake,
// muxes the active pattern to the LEDs and guards each state with a watchdog.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_STATES     = 4,
    parameter int unsigned LED_W          = LED_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDX_W         = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_async_rs_n,
    input  logic                        i_run,
    input  logic                        i_loop_mode,
    input  logic                        i_hold,
    input  logic [NUM_STATES-1:0]       i_st_over,
    input  logic [NUM_STATES*LED_W-1:0] i_pat_in,
    output logic [NUM_STATES-1:0]       o_st_begin,
    output logic                        o_enabler,
    output logic [LED_W-1:0]            o_led_out,
    output logic [IDX_W-1:0]            o_cur_idx,
    output logic                        o_seq_done,
    output logic                        o_timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_d;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_d;
    logic [NUM_STATES-1:0]  r_st_begin;
    logic                   r_enabler;
    logic [LED_W-1:0]       r_led;
    logic [LED_W-1:0]       w_slice;
    logic                   r_seq_done;
    logic                   r_timeout_err;
    logic                   w_expire;
    logic                   w_wd_clear;
    logic                   w_wd_count;

    assign w_wd_clear = (w_state_d == ST_ACTIVE) && (r_state != ST_ACTIVE);
    assign w_wd_count = (r_state == ST_ACTIVE) && r_enabler;
    assign w_slice    = i_pat_in[w_idx_d * LED_W +: LED_W];

    led_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk        (i_clk),
        .i_async_rs_n (i_async_rs_n),
        .i_clear      (w_wd_clear),
        .i_count      (w_wd_count),
        .i_hold       (i_hold),
        .o_expire     (w_expire)
    );

    // run=0 overrides everything; st_over beats a coincident watchdog expiry.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        if (!i_run) begin
            w_state_d = ST_IDLE;
            w_idx_d   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_d = ST_ACTIVE;
                    w_idx_d   = '0;
                end
                ST_ACTIVE: begin
                    if (i_st_over[r_idx]) begin
                        w_state_d = ST_GAP;
                    end else if (w_expire) begin
                        w_state_d = ST_ERROR;
                    end
                end
                ST_GAP: begin
                    if (r_idx != LAST_IDX) begin
                        w_state_d = ST_ACTIVE;
                        w_idx_d   = r_idx + 1'b1;
                    end else if (i_loop_mode) begin
                        w_state_d = ST_ACTIVE;
                        w_idx_d   = '0;
                    end else begin
                        w_state_d = ST_DONE;
                    end
                end
                ST_DONE, ST_ERROR: ;
                default: begin
                    w_state_d = ST_IDLE;
                    w_idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state change.
    always_ff @(posedge i_clk or negedge i_async_rs_n) begin
        if (!i_async_rs_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_st_begin    <= '0;
            r_enabler     <= 1'b0;
            r_led         <= '0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_idx         <= w_idx_d;
            r_st_begin    <= (w_state_d == ST_ACTIVE) ? (NUM_STATES'(1) << w_idx_d) : '0;
            r_enabler     <= (w_state_d == ST_ACTIVE) && !i_hold;
            r_seq_done    <= (w_state_d == ST_DONE);
            r_timeout_err <= (w_state_d == ST_ERROR);
            case (w_state_d)
                ST_ACTIVE: r_led <= w_slice;
                ST_GAP:    r_led <= r_led;
                default:   r_led <= LED_W'(LED_OFF);
            endcase
        end
    end

    assign o_st_begin    = r_st_begin;
    assign o_enabler     = r_enabler;
    assign o_led_out     = r_led;
    assign o_cur_idx     = r_idx;
    assign o_seq_done    = r_seq_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: behavioural pattern blocks answer the handshake and a
// scoreboard of expected begin/index/LED triples is checked at each state entry.
module tb_led_seq_ctrl;

    typedef struct packed {
        logic [3:0]  sb;
        logic [1:0]  idx;
        logic [17:0] led;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        loop_mode;
    logic        hold;
    logic [3:0]  fmask;
    logic [71:0] pat;
    int          dly [4];

    logic [3:0]  over [2];
    logic [3:0]  sb   [2];
    logic        en   [2];
    logic [17:0] led  [2];
    logic [1:0]  idx  [2];
    logic        done [2];
    logic        err  [2];

    int          n_checks;
    int          n_fail;
    exp_t        sb_q [$];
    logic        mon_en;
    logic        mon_gap;
    logic [3:0]  prev_sb;
    logic [17:0] prev_led;

    always #5 clk = ~clk;

    // Instance 0 uses the default watchdog, instance 1 a short one for the hold test.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [3:0] over_r;
        int         mcnt [4];

        led_seq_ctrl #(
            .NUM_STATES     (4),
            .LED_W          (18),
            .TIMEOUT_CYCLES (k == 0 ? 64 : 20)
        ) u_dut (
            .i_clk         (clk),
            .i_async_rs_n  (rst_n),
            .i_run         (run),
            .i_loop_mode   (loop_mode),
            .i_hold        (hold),
            .i_st_over     (over[k]),
            .i_pat_in      (pat),
            .o_st_begin    (sb[k]),
            .o_enabler     (en[k]),
            .o_led_out     (led[k]),
            .o_cur_idx     (idx[k]),
            .o_seq_done    (done[k]),
            .o_timeout_err (err[k])
        );

        assign over[k] = over_r | fmask;

        // Pattern block model: counts enabled cycles, restarts when begin or enabler drops.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                over_r <= '0;
                for (int i = 0; i < 4; i++) mcnt[i] <= 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (sb[k][i] && en[k]) begin
                        mcnt[i]   <= mcnt[i] + 1;
                        over_r[i] <= (mcnt[i] + 1 >= dly[i]);
                    end else begin
                        mcnt[i]   <= 0;
                        over_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [17:0] slice(input int i);
        return pat[i*18 +: 18];
    endfunction

    task automatic push_exp(input int i);
        exp_t e;
        e.sb  = 4'(1 << i);
        e.idx = 2'(i);
        e.led = slice(i);
        sb_q.push_back(e);
    endtask

    task automatic wait_sb(input int k, input logic [3:0] target, input int budget,
                           input string tag);
        int n = 0;
        while (sb[k] != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb[k]), 32'(target));
    endtask

    // Scoreboard: pop on every rising st_begin, check LED hold on every falling one.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (prev_sb == 4'b0 && sb[0] != 4'b0) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexp", 32'(sb[0]), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_seq", 32'(sb[0]), 32'(e.sb));
                    check("sb_idx", 32'(idx[0]), 32'(e.idx));
                    check("sb_led", 32'(led[0]), 32'(e.led));
                end
            end else if (mon_gap && prev_sb != 4'b0 && sb[0] == 4'b0) begin
                check("gap_led", 32'(led[0]), 32'(prev_led));
            end
        end
        prev_sb  = sb[0];
        prev_led = led[0];
    end

    initial begin
        int n;
        clk       = 1'b0;
        rst_n     = 1'b0;
        run       = 1'b0;
        loop_mode = 1'b0;
        hold      = 1'b0;
        fmask     = 4'b0;
        pat       = {18'h3C3C3, 18'h2A5A5, 18'h1F00F, 18'h0F0F1};
        for (int i = 0; i < 4; i++) dly[i] = 16;
        mon_en    = 1'b0;
        mon_gap   = 1'b0;
        prev_sb   = '0;
        prev_led  = '0;
        n_checks  = 0;
        n_fail    = 0;

        repeat (3) @(negedge clk);
        check("rst_sb", 32'(sb[0]), 32'd0);
        check("rst_en", 32'(en[0]), 32'd0);
        check("rst_led", 32'(led[0]), 32'd0);
        check("rst_idx", 32'(idx[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sb", 32'(sb[0]), 32'd0);

        // One-shot sequence through all four states.
        for (int i = 0; i < 4; i++) push_exp(i);
        mon_en  = 1'b1;
        mon_gap = 1'b1;
        run     = 1'b1;
        @(negedge clk);
        check("start_sb", 32'(sb[0]), 32'd1);
        check("start_en", 32'(en[0]), 32'd1);
        repeat (3) @(negedge clk);
        fmask = 4'b1000;
        @(negedge clk);
        fmask = 4'b0;
        @(negedge clk);
        check("ign_sb", 32'(sb[0]), 32'd1);
        check("ign_idx", 32'(idx[0]), 32'd0);
        wait_sb(0, 4'b0010, 100, "wait_s1");
        @(negedge clk);
        pat[18 +: 18] = 18'h15555;
        @(negedge clk);
        check("led_lat", 32'(led[0]), 32'h15555);
        n = 0;
        while (!done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_flag", 32'(done[0]), 32'd1);
        check("done_sb", 32'(sb[0]), 32'd0);
        check("done_en", 32'(en[0]), 32'd0);
        check("done_led", 32'(led[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done[0]), 32'd1);
        check("sb_empty1", 32'(sb_q.size()), 32'd0);
        run = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done[0]), 32'd0);

        // Looping sequence, then run dropped together with st_over.
        loop_mode = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i);
        push_exp(0);
        push_exp(1);
        run = 1'b1;
        wait_sb(0, 4'b1000, 200, "wait_s3");
        @(negedge clk);
        wait_sb(0, 4'b0001, 100, "wrap_sb");
        check("wrap_idx", 32'(idx[0]), 32'd0);
        check("wrap_done", 32'(done[0]), 32'd0);
        wait_sb(0, 4'b0010, 100, "wrap_s1");
        n = 0;
        while (!over[0][1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drop_over", 32'(over[0][1]), 32'd1);
        mon_en  = 1'b0;
        mon_gap = 1'b0;
        run     = 1'b0;
        @(negedge clk);
        check("drop_sb", 32'(sb[0]), 32'd0);
        check("drop_en", 32'(en[0]), 32'd0);
        check("drop_led", 32'(led[0]), 32'd0);
        check("drop_idx", 32'(idx[0]), 32'd0);
        check("drop_done", 32'(done[0]), 32'd0);
        check("sb_empty2", 32'(sb_q.size()), 32'd0);

        // Block 2 never finishes: watchdog fires after exactly 64 enabled cycles.
        loop_mode = 1'b0;
        dly[2]    = 100000;
        run       = 1'b1;
        wait_sb(0, 4'b0100, 200, "wait_wd");
        repeat (63) @(negedge clk);
        check("wd_pre_err", 32'(err[0]), 32'd0);
        check("wd_pre_sb", 32'(sb[0]), 32'd4);
        @(negedge clk);
        check("wd_err", 32'(err[0]), 32'd1);
        check("wd_sb", 32'(sb[0]), 32'd0);
        check("wd_led", 32'(led[0]), 32'd0);
        check("wd_en", 32'(en[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("wd_sticky", 32'(err[0]), 32'd1);
        run = 1'b0;
        @(negedge clk);
        check("wd_clear", 32'(err[0]), 32'd0);
        dly[2] = 16;

        // Hold mid-state 1 on the short-watchdog instance.
        dly[1] = 15;
        run    = 1'b1;
        wait_sb(1, 4'b0010, 100, "wait_hold");
        repeat (2) @(negedge clk);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_en", 32'(en[1]), 32'd0);
        check("hold_sb", 32'(sb[1]), 32'd2);
        check("hold_idx", 32'(idx[1]), 32'd1);
        repeat (8) @(negedge clk);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rel_en", 32'(en[1]), 32'd1);
        wait_sb(1, 4'b0100, 100, "hold_next");
        check("hold_no_to", 32'(err[1]), 32'd0);
        run    = 1'b0;
        dly[1] = 16;
        @(negedge clk);

        // Asynchronous reset in the middle of state 2.
        run = 1'b1;
        wait_sb(0, 4'b0100, 200, "wait_ar");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_sb", 32'(sb[0]), 32'd0);
        check("ar_en", 32'(en[0]), 32'd0);
        check("ar_led", 32'(led[0]), 32'd0);
        check("ar_idx", 32'(idx[0]), 32'd0);
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_idle", 32'(sb[0]), 32'd0);
        run = 1'b1;
        @(negedge clk);
        check("ar_restart", 32'(sb[0]), 32'd1);
        run = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer on the initiating side of the LED pattern-state handshake.
- Asserts one st_begin at a time and holds the shared enabler.
- Waits for the matching st_over, then advances to the next pattern state.
- Muxes the active state's LED pattern to the board LEDs and guards each state with a watchdog.

Parameters:
- NUM_STATES, 4, number of pattern-state blocks sequenced (indices 0..NUM_STATES-1).
- LED_W, 18, LED bus width per pattern block and at the output.
- TIMEOUT_CYCLES, 64, enabled cycles allowed in one state before st_over is declared missing.

Ports:
- clk  in  1  pattern clock; all logic on its rising edge.
- async_rs_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = sequence runs, 0 = return to IDLE.
- loop_mode  in  1  1 = wrap from last state to state 0; 0 = stop after last state.
- hold  in  1  level; freezes the sequence and drops enabler.
- st_over  in  NUM_STATES  done flags from the pattern blocks.
- pat_in  in  NUM_STATES*LED_W  concatenated patterns; slice i = pat_in[i*LED_W +: LED_W].
- st_begin  out  NUM_STATES  one-hot or zero; begin for the active pattern block.
- enabler  out  1  shared enable to all pattern blocks.
- led_out  out  LED_W  registered LED drive.
- cur_idx  out  clog2(NUM_STATES)  index of the active state.
- seq_done  out  1  one-shot sequence finished (loop_mode=0).
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async_rs_n=0, asynchronous): FSM=IDLE, st_begin=0, enabler=0, led_out=0, cur_idx=0, seq_done=0, timeout_err=0, watchdog=0.
- FSM states: IDLE, ACTIVE, GAP, DONE, ERROR. All outputs are registered.
- IDLE
  - All outputs 0.
  - run=1 → ACTIVE with cur_idx=0.
  - st_begin[0]=1 and enabler=1 are visible on the cycle after run is sampled high.
- ACTIVE
  - st_begin = 1<<cur_idx.
  - enabler = ~hold, registered with 1-cycle latency.
  - led_out = pat_in slice cur_idx, registered with 1-cycle latency.
  - st_over[cur_idx]=1 → GAP. st_over bits of other indices are ignored.
- GAP (exactly 1 cycle)
  - st_begin=0 so the finished block resets its pattern and clears its st_over.
  - led_out holds its last value.
  - If cur_idx<NUM_STATES-1: cur_idx+1, then ACTIVE.
  - If cur_idx=NUM_STATES-1 and loop_mode=1: cur_idx=0, then ACTIVE.
  - If cur_idx=NUM_STATES-1 and loop_mode=0: DONE.
- DONE
  - seq_done=1, st_begin=0, enabler=0, led_out=0.
  - Stays until run=0.
- Watchdog
  - Counts cycles in ACTIVE with enabler=1.
  - Clears on entry to ACTIVE.
  - Holds its value while hold=1.
  - Reaching TIMEOUT_CYCLES before st_over → ERROR.
- ERROR
  - timeout_err=1 (sticky), st_begin=0, enabler=0, led_out=0.
  - Exits only on run=0 → IDLE, which clears timeout_err.
- hold=1 in ACTIVE
  - enabler=0, so the pattern block restarts its pattern.
  - st_begin stays asserted and cur_idx is unchanged.
  - On release the current state restarts from its initial pattern.
- run=0 in any state → IDLE on the next clk edge. run=0 has priority over a simultaneous st_over or watchdog expiry.
- Simultaneous st_over[cur_idx] and watchdog expiry: st_over wins, → GAP.
- loop_mode is sampled only in GAP of the last state.
- Reset mid-operation: all outputs drop immediately (asynchronous); restart requires run=1 after release.

Decomposition:
- Package led_pkg holds:
  - FSM state encoding (IDLE, ACTIVE, GAP, DONE, ERROR);
  - default LED_W=18;
  - an all-off LED constant.
- One natural sub-module, led_seq_watchdog: counter with clear, hold and terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset then run=1; each model block asserts st_over 16 cycles after begin.
  - st_begin sequence 0001, 0010, 0100, 1000, with 1 zero cycle between each.
  - led_out tracks each slice 1 cycle late.
  - loop_mode=0: seq_done=1 after state 3.
- loop_mode=1, same stimulus: after state 3's GAP, st_begin=0001 and cur_idx=0; seq_done stays 0.
- State 2 never asserts st_over:
  - timeout_err=1 exactly 64 enabled cycles after st_begin=0100;
  - st_begin=0, led_out=0;
  - run=0 clears the error.
- hold=1 for 10 cycles mid-state 1:
  - enabler=0, st_begin stays 0010, watchdog frozen;
  - no timeout with TIMEOUT_CYCLES=20 and block done 15 enabled cycles after release.
- st_over[3] pulsed while state 0 is active → ignored, st_begin stays 0001.
- run=0 in the same cycle as st_over[cur_idx] → IDLE, all outputs 0.
- async_rs_n low mid-state 2 → outputs 0 immediately.
